unidad_control_multiciclo: RTL and testbench
============================================

Name: unidad_control_multiciclo

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and write-back for each instruction. It drives the 2-bit operacion_alu code consumed by the ALU control decoder, plus all register, memory and PC strobes. Shared instruction/data memory accesses are stretched by a ready handshake, with a timeout watchdog.

Parameters:
ESPERA_MAX, 15, max consecutive cycles waiting on mem_listo before the FSM enters ERROR; 0 disables the timeout.
ANCHO_CONT, 4, width of the wait counter; must satisfy 2^ANCHO_CONT > ESPERA_MAX.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], valid from DECODE onward
mem_listo  in  1  memory ready: current read/write completes this cycle
pc_escribir  out  1  unconditional PC write
pc_escribir_cond  out  1  PC write if ALU zero
iord  out  1  0 = memory address from PC, 1 = from ALU out
mem_leer  out  1  memory read request
mem_escribir  out  1  memory write request
ir_escribir  out  1  IR load
mem_a_reg  out  1  write-back source: 1 = MDR, 0 = ALU out
reg_dst  out  1  destination: 1 = rd, 0 = rt
reg_escribir  out  1  register file write
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
pc_fuente  out  2  00 = ALU result, 01 = ALU out, 10 = jump target
operacion_alu  out  2  00 = add, 01 = sub, 10 = R-type function field
instr_invalida  out  1  one-cycle pulse on unknown opcode
error  out  1  sticky memory timeout flag
estado  out  4  current state, for debug

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. Reset forces state FETCH, the wait counter to 0, and instr_invalida and error to 0.
- All outputs are combinational from state, except where gated by mem_listo as noted below. Immediately after reset, the FETCH outputs are driven, so mem_leer=1.
- Any signal not listed for a state is 0.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11, ERROR=15.
- FETCH: mem_leer=1, iord=0, alu_src_a=0, alu_src_b=01, operacion_alu=00, pc_fuente=00. ir_escribir and pc_escribir equal mem_listo. Go to DECODE when mem_listo=1, else stay.
- DECODE: alu_src_a=0, alu_src_b=11, operacion_alu=00. Next state by opcode:
  - 100011 (LW) or 101011 (SW): MEM_ADDR.
  - 000000: R_EXEC.
  - 000100: BRANCH.
  - 000010: JUMP.
  - 001000 (ADDI): see Optional Feature.
  - Any other opcode: FETCH, and instr_invalida=1 on the following cycle only.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, operacion_alu=00. Go to MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: mem_leer=1, iord=1. Go to MEM_WB when mem_listo=1, else stay.
- MEM_WB: reg_dst=0, mem_a_reg=1, reg_escribir=1. Go to FETCH.
- MEM_WRITE: mem_escribir=1, iord=1. Go to FETCH when mem_listo=1, else stay.
- R_EXEC: alu_src_a=1, alu_src_b=00, operacion_alu=10. Go to R_WB.
- R_WB: reg_dst=1, mem_a_reg=0, reg_escribir=1. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, operacion_alu=01, pc_escribir_cond=1, pc_fuente=01. Go to FETCH.
- JUMP: pc_escribir=1, pc_fuente=10. Go to FETCH.
- Cycles per instruction, with memory ready immediately: LW 5, SW 4, R-type 4, BEQ 3, J 3.
- Wait counter and timeout:
  - Cleared on entry to FETCH, MEM_READ or MEM_WRITE.
  - Increments each cycle in those states while mem_listo=0; saturates at ESPERA_MAX.
  - If ESPERA_MAX>0, the counter equals ESPERA_MAX and mem_listo=0, the next state is ERROR.
  - mem_listo=1 in the same cycle as the limit is reached takes priority: the access completes normally.
- ERROR: all strobes 0, error=1. Stays in ERROR until rst_n is asserted.
- Reset asserted mid-instruction: the FSM aborts immediately and no strobe remains asserted.
- opcode is sampled only in DECODE; changes in other states are ignored.

Optional Feature:
Macro ADDI_EN.
- Defined: opcode 001000 goes DECODE -> ADDI_EXEC -> ADDI_WB -> FETCH (4 cycles).
  - ADDI_EXEC: alu_src_a=1, alu_src_b=10, operacion_alu=00.
  - ADDI_WB: reg_dst=0, mem_a_reg=0, reg_escribir=1.
- Undefined: opcode 001000 is treated as invalid (instr_invalida pulse, return to FETCH), and states 10/11 are unreachable.

Test Plan:
- Reset with mem_listo=1 held: estado=0, mem_leer=1, error=0. One cycle after rst_n rises, ir_escribir=pc_escribir=1 and estado becomes 1.
- R-type (opcode 000000), mem_listo=1: estado sequence 0,1,6,7,0. operacion_alu=10 in state 6; reg_escribir=1 and reg_dst=1 in state 7.
- LW with mem_listo low 3 cycles in MEM_READ: estado 0,1,2,3,3,3,3,4,0. mem_leer=iord=1 throughout state 3; mem_a_reg=1 in state 4.
- BEQ then J: BEQ gives states 0,1,8 with operacion_alu=01, pc_escribir_cond=1, pc_fuente=01. J gives states 0,1,9 with pc_escribir=1, pc_fuente=10.
- Opcode 111111: 0,1,0 with instr_invalida high exactly one cycle. Opcode 001000: same result without ADDI_EN; 0,1,10,11,0 with ADDI_EN.
- mem_listo held 0 in FETCH with ESPERA_MAX=15: ERROR reached after 15 wait cycles, error=1 and all strobes 0. Asserting rst_n mid-wait returns to FETCH with error=0.

Source files
------------

// File: rtl/unidad_control_multiciclo.sv
// Main control FSM of the multicycle MIPS datapath, with memory-ready wait and timeout watchdog.
// Optional macro ADDI_EN adds the ADDI_EXEC/ADDI_WB path for opcode 001000.
module unidad_control_multiciclo #(
  parameter int ESPERA_MAX = 15,
  parameter int ANCHO_CONT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_listo,
  output logic       pc_escribir,
  output logic       pc_escribir_cond,
  output logic       iord,
  output logic       mem_leer,
  output logic       mem_escribir,
  output logic       ir_escribir,
  output logic       mem_a_reg,
  output logic       reg_dst,
  output logic       reg_escribir,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_fuente,
  output logic [1:0] operacion_alu,
  output logic       instr_invalida,
  output logic       error,
  output logic [3:0] estado
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11,
    ERROR     = 4'd15
  } estado_t;

  localparam logic [ANCHO_CONT-1:0] LIMITE = ANCHO_CONT'(ESPERA_MAX);

  estado_t               state, state_next;
  logic [ANCHO_CONT-1:0] cont, cont_next;
  logic                  es_sw, es_sw_next;
  logic                  invalida_next;
  logic                  en_espera;
  logic                  agotado;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= FETCH;
      cont           <= '0;
      es_sw          <= 1'b0;
      instr_invalida <= 1'b0;
    end else begin
      state          <= state_next;
      cont           <= cont_next;
      es_sw          <= es_sw_next;
      instr_invalida <= invalida_next;
    end
  end

  assign en_espera = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
  assign agotado   = (ESPERA_MAX > 0) && en_espera && !mem_listo && (cont == LIMITE);

  // Counter runs only while a memory access is stalled; any other cycle clears it,
  // so every entry into a waiting state starts from zero.
  always_comb begin
    cont_next = '0;
    if (en_espera && !mem_listo) begin
      if (cont != LIMITE) cont_next = cont + ANCHO_CONT'(1);
      else                cont_next = cont;
    end
  end

  always_comb begin
    state_next    = state;
    es_sw_next    = es_sw;
    invalida_next = 1'b0;
    case (state)
      FETCH:     if (mem_listo) state_next = DECODE;
      DECODE: begin
        case (opcode)
          6'b100011: begin state_next = MEM_ADDR; es_sw_next = 1'b0; end
          6'b101011: begin state_next = MEM_ADDR; es_sw_next = 1'b1; end
          6'b000000: state_next = R_EXEC;
          6'b000100: state_next = BRANCH;
          6'b000010: state_next = JUMP;
`ifdef ADDI_EN
          6'b001000: state_next = ADDI_EXEC;
`endif
          default: begin
            state_next    = FETCH;
            invalida_next = 1'b1;
          end
        endcase
      end
      MEM_ADDR:  state_next = es_sw ? MEM_WRITE : MEM_READ;
      MEM_READ:  if (mem_listo) state_next = MEM_WB;
      MEM_WB:    state_next = FETCH;
      MEM_WRITE: if (mem_listo) state_next = FETCH;
      R_EXEC:    state_next = R_WB;
      R_WB:      state_next = FETCH;
      BRANCH:    state_next = FETCH;
      JUMP:      state_next = FETCH;
`ifdef ADDI_EN
      ADDI_EXEC: state_next = ADDI_WB;
      ADDI_WB:   state_next = FETCH;
`endif
      ERROR:     state_next = ERROR;
      default:   state_next = FETCH;
    endcase
    // A ready in the same cycle as the limit wins, since agotado requires !mem_listo.
    if (agotado) state_next = ERROR;
  end

  always_comb begin
    pc_escribir      = 1'b0;
    pc_escribir_cond = 1'b0;
    iord             = 1'b0;
    mem_leer         = 1'b0;
    mem_escribir     = 1'b0;
    ir_escribir      = 1'b0;
    mem_a_reg        = 1'b0;
    reg_dst          = 1'b0;
    reg_escribir     = 1'b0;
    alu_src_a        = 1'b0;
    alu_src_b        = 2'b00;
    pc_fuente        = 2'b00;
    operacion_alu    = 2'b00;
    error            = 1'b0;
    case (state)
      FETCH: begin
        mem_leer    = 1'b1;
        alu_src_b   = 2'b01;
        ir_escribir = mem_listo;
        pc_escribir = mem_listo;
      end
      DECODE:    alu_src_b = 2'b11;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_READ: begin
        mem_leer = 1'b1;
        iord     = 1'b1;
      end
      MEM_WB: begin
        mem_a_reg    = 1'b1;
        reg_escribir = 1'b1;
      end
      MEM_WRITE: begin
        mem_escribir = 1'b1;
        iord         = 1'b1;
      end
      R_EXEC: begin
        alu_src_a     = 1'b1;
        operacion_alu = 2'b10;
      end
      R_WB: begin
        reg_dst      = 1'b1;
        reg_escribir = 1'b1;
      end
      BRANCH: begin
        alu_src_a        = 1'b1;
        operacion_alu    = 2'b01;
        pc_escribir_cond = 1'b1;
        pc_fuente        = 2'b01;
      end
      JUMP: begin
        pc_escribir = 1'b1;
        pc_fuente   = 2'b10;
      end
`ifdef ADDI_EN
      ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDI_WB:   reg_escribir = 1'b1;
`endif
      ERROR:     error = 1'b1;
      default: ;
    endcase
  end

  assign estado = state;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Bench for unidad_control_multiciclo: per-instruction expected state traces built from the
// instruction timing rules, random memory stalls and don't-care inputs, checked every cycle.
module tb_unidad_control_multiciclo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_listo = 1'b1;
  logic       pc_escribir, pc_escribir_cond, iord, mem_leer, mem_escribir, ir_escribir;
  logic       mem_a_reg, reg_dst, reg_escribir, alu_src_a;
  logic [1:0] alu_src_b, pc_fuente, operacion_alu;
  logic       instr_invalida, error;
  logic [3:0] estado;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         st;
    bit         ml;
    logic [5:0] op;
    bit         inv;
  } paso_t;

  paso_t pasos[$];
  bit    pend_inv = 1'b0;

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

  unidad_control_multiciclo dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_listo(mem_listo),
    .pc_escribir(pc_escribir), .pc_escribir_cond(pc_escribir_cond), .iord(iord),
    .mem_leer(mem_leer), .mem_escribir(mem_escribir), .ir_escribir(ir_escribir),
    .mem_a_reg(mem_a_reg), .reg_dst(reg_dst), .reg_escribir(reg_escribir),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_fuente(pc_fuente),
    .operacion_alu(operacion_alu), .instr_invalida(instr_invalida), .error(error),
    .estado(estado)
  );

  always #5 clk = ~clk;

  // Output vector order: pc_escribir, pc_escribir_cond, iord, mem_leer, mem_escribir,
  // ir_escribir, mem_a_reg, reg_dst, reg_escribir, alu_src_a, alu_src_b, pc_fuente, op, error
  function automatic logic [16:0] exp_out(input int st, input bit ml);
    logic pw = 0, pwc = 0, io = 0, rd = 0, wr = 0, irw = 0, m2r = 0, dst = 0, rw = 0, sa = 0, er = 0;
    logic [1:0] sb = 0, pf = 0, op = 0;
    case (st)
      0:  begin rd = 1; sb = 2'b01; irw = ml; pw = ml; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin rd = 1; io = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin wr = 1; io = 1; end
      6:  begin sa = 1; op = 2'b10; end
      7:  begin dst = 1; rw = 1; end
      8:  begin sa = 1; op = 2'b01; pwc = 1; pf = 2'b01; end
      9:  begin pw = 1; pf = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      15: er = 1;
      default: ;
    endcase
    return {pw, pwc, io, rd, wr, irw, m2r, dst, rw, sa, sb, pf, op, er};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int st, input bit ml, input bit inv);
    check_output({tag, " estado"}, 32'(estado), 32'(st));
    check_output({tag, " outputs"},
                 32'({pc_escribir, pc_escribir_cond, iord, mem_leer, mem_escribir, ir_escribir,
                      mem_a_reg, reg_dst, reg_escribir, alu_src_a, alu_src_b, pc_fuente,
                      operacion_alu, error}),
                 32'(exp_out(st, ml)));
    check_output({tag, " instr_invalida"}, 32'(instr_invalida), 32'(inv));
  endtask

  task automatic push(input int st, input bit ml, input logic [5:0] op);
    paso_t p;
    p.st = st; p.ml = ml; p.op = op; p.inv = 1'b0;
    if (st == 0 && pend_inv) begin
      p.inv = 1'b1;
      pend_inv = 1'b0;
    end
    pasos.push_back(p);
  endtask

  // A stalled access occupies w low-ready cycles and then one completing cycle.
  task automatic add_wait(input int st, input int w);
    for (int i = 0; i <= w; i++) push(st, (i == w), 6'($urandom));
  endtask

  task automatic add_instr(input logic [5:0] op, input int wf, input int wm);
    add_wait(0, wf);
    push(1, 1'($urandom), op);
    case (op)
      OP_LW:   begin push(2, 1'($urandom), 6'($urandom)); add_wait(3, wm); push(4, 1'($urandom), 6'($urandom)); end
      OP_SW:   begin push(2, 1'($urandom), 6'($urandom)); add_wait(5, wm); end
      OP_R:    begin push(6, 1'($urandom), 6'($urandom)); push(7, 1'($urandom), 6'($urandom)); end
      OP_BEQ:  push(8, 1'($urandom), 6'($urandom));
      OP_J:    push(9, 1'($urandom), 6'($urandom));
`ifdef ADDI_EN
      OP_ADDI: begin push(10, 1'($urandom), 6'($urandom)); push(11, 1'($urandom), 6'($urandom)); end
`endif
      default: pend_inv = 1'b1;
    endcase
  endtask

  // Plays up to n queued cycles (n < 0: all), starting and ending on a falling edge.
  task automatic apply_stimulus(input int n);
    int k = 0;
    while (pasos.size() > 0 && (n < 0 || k < n)) begin
      paso_t p = pasos.pop_front();
      mem_listo = p.ml;
      opcode    = p.op;
      #1;
      check_all($sformatf("cyc%0d st%0d", k, p.st), p.st, p.ml, p.inv);
      @(negedge clk);
      k++;
    end
  endtask

  task automatic do_reset(input string tag);
    pasos.delete();
    pend_inv  = 1'b0;
    rst_n     = 1'b0;
    mem_listo = 1'b1;
    #1;
    check_all({tag, " async"}, 0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    check_all({tag, " held"}, 0, 1'b1, 1'b0);
    rst_n = 1'b1;
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] ops[7];
    logic [5:0] r;
    ops = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_J, OP_ADDI, 6'b111111};
    r = ops[$urandom_range(0, 6)];
    if (r == 6'b111111) begin
      r = 6'($urandom);
      if (r inside {OP_LW, OP_SW, OP_R, OP_BEQ, OP_J, OP_ADDI}) r = 6'b111111;
    end
    return r;
  endfunction

  initial begin
    $display("[TB] start");
    do_reset("reset");

    add_instr(OP_R, 0, 0);
    add_instr(OP_LW, 0, 3);
    add_instr(OP_BEQ, 0, 0);
    add_instr(OP_J, 0, 0);
    add_instr(6'b111111, 0, 0);
    add_instr(OP_ADDI, 0, 0);
    add_instr(OP_SW, 15, 15);
    add_instr(OP_LW, 2, 15);
    apply_stimulus(-1);

    for (int i = 0; i < 40; i++) begin
      int wf = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
      int wm = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
      add_instr(pick_op(), wf, wm);
    end
    add_instr(OP_R, 0, 0);
    apply_stimulus(-1);

    $display("[TB] reset during a stalled load");
    add_instr(OP_LW, 1, 10);
    apply_stimulus(8);
    #2;
    do_reset("midwait");

    $display("[TB] fetch timeout");
    for (int i = 0; i < 16; i++) push(0, 1'b0, 6'($urandom));
    for (int i = 0; i < 4; i++) push(15, 1'($urandom), 6'($urandom));
    apply_stimulus(-1);
    #2;
    do_reset("after_err");

    $display("[TB] memory read timeout");
    add_wait(0, 0);
    push(1, 1'b1, OP_LW);
    push(2, 1'b1, 6'($urandom));
    for (int i = 0; i < 16; i++) push(3, 1'b0, 6'($urandom));
    for (int i = 0; i < 3; i++) push(15, 1'($urandom), 6'($urandom));
    apply_stimulus(-1);
    #2;
    do_reset("after_err2");

    add_instr(OP_SW, 0, 0);
    add_instr(OP_R, 0, 0);
    apply_stimulus(-1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
